// File: rtl/channel_util_pkg.sv
// channel_util_pkg: shared types and helpers for the Channel utility blocks.
// Holds the deserializer FILL/HOLD state enum and the beat-counter width helper.
package channel_util_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } deser_state_e;

    // A counter that spans 0..k-1 still needs one bit when k is 1.
    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/Channel.svh
// Channel.svh: port-bundle macros for a valid/accept Channel (d, v forward; a backward).
// Each macro takes the three port names of the channel and the data width.
`ifndef CHANNEL_SVH
`define CHANNEL_SVH

`define CHANNEL_SNK_PORTS(d, v, a, w) \
    input  logic [(w)-1:0] d, \
    input  logic           v, \
    output logic           a

`define CHANNEL_SRC_PORTS(d, v, a, w) \
    output logic [(w)-1:0] d, \
    output logic           v, \
    input  logic           a

`endif

// File: rtl/channel_deserializer.sv
// channel_deserializer: packs K narrow NIN-bit beats (first beat in the LSBs) into one wide word.
// Defining CHANNEL_DESER_FLUSH_EN adds a flush input that emits a partial, zero-padded word.
`include "Channel.svh"

module channel_deserializer
    import channel_util_pkg::*;
#(
    parameter int NIN = 8,
    parameter int K   = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef CHANNEL_DESER_FLUSH_EN
    input  logic flush,
`endif
    `CHANNEL_SNK_PORTS(in_d, in_v, in_a, NIN),
    `CHANNEL_SRC_PORTS(out_d, out_v, out_a, NIN * K)
);

    localparam int CW = cnt_width(K);
    localparam int W  = NIN * K;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    deser_state_e  state_r;
    deser_state_e  state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [W-1:0]  word_r;
    logic [W-1:0]  word_s;
    logic          in_a_s;
    logic          accept_s;

    // Input accept: open in FILL, in HOLD only when the held word leaves this cycle.
    always_comb begin
        in_a_s = 1'b0;
        if (!reset) begin
            in_a_s = 1'b0;
        end else if (state_r == HOLD) begin
            in_a_s = in_v & out_a;
        end else begin
            in_a_s = in_v;
        end
    end

    assign accept_s = in_v & in_a_s;

    // Next state, beat counter and word register.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        word_s  = word_r;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    for (int i = 0; i < K; i++) begin
                        if (cnt_r == CW'(i)) begin
                            word_s[i*NIN +: NIN] = in_d;
                        end else begin
                            word_s[i*NIN +: NIN] = word_r[i*NIN +: NIN];
                        end
                    end
                    if (cnt_r == CNT_LAST) begin
                        state_s = HOLD;
                        cnt_s   = '0;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
`ifdef CHANNEL_DESER_FLUSH_EN
                // Evaluated after the beat so a coinciding beat is part of the flushed word.
                if (flush && (state_s == FILL) && (cnt_s != '0)) begin
                    state_s = HOLD;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_s;
                end
`endif
            end
            HOLD: begin
                if (out_a) begin
                    word_s = '0;
                    if (accept_s) begin
                        word_s[NIN-1:0] = in_d;
                        if (K == 1) begin
                            state_s = HOLD;
                            cnt_s   = '0;
                        end else begin
                            state_s = FILL;
                            cnt_s   = CNT_ONE;
                        end
                    end else begin
                        state_s = FILL;
                        cnt_s   = '0;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = FILL;
                cnt_s   = '0;
                word_s  = '0;
            end
        endcase
    end

    // State, counter and word registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FILL;
            cnt_r   <= '0;
            word_r  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            word_r  <= word_s;
        end
    end

    assign in_a  = in_a_s;
    assign out_d = word_r;
    assign out_v = (state_r == HOLD);

endmodule

// File: tb/tb_channel_deserializer.sv
// tb_channel_deserializer: queue-based reference model of the deserializer checked every cycle,
// plus directed scenarios with literal expectations; flush scenarios need CHANNEL_DESER_FLUSH_EN.
module tb_channel_deserializer;

    localparam int NIN = 8;
    localparam int K   = 4;
    localparam int W   = NIN * K;

    logic           clk;
    logic           reset;
    logic [NIN-1:0] in_d;
    logic           in_v;
    logic           in_a;
    logic [W-1:0]   out_d;
    logic           out_v;
    logic           out_a;
`ifdef CHANNEL_DESER_FLUSH_EN
    logic           flush;
`endif

    int n_cmp;
    int n_err;

    // Reference model: beats gathered so far, and the word on offer (if any).
    logic [NIN-1:0] m_beats[$];
    logic           m_off;
    logic [W-1:0]   m_word;
    logic           exp_in_a;
    logic           was_off;
    logic [W-1:0]   got[$];

    channel_deserializer #(.NIN(NIN), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef CHANNEL_DESER_FLUSH_EN
        .flush (flush),
`endif
        .in_d  (in_d),
        .in_v  (in_v),
        .in_a  (in_a),
        .out_d (out_d),
        .out_v (out_v),
        .out_a (out_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_beats();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < m_beats.size(); i++) begin
            w[i*NIN +: NIN] = m_beats[i];
        end
        return w;
    endfunction

    // Per-cycle compare of DUT outputs against the model, then advance the model.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            chk("rst_in_a", 64'(in_a), 64'd0);
            chk("rst_out_v", 64'(out_v), 64'd0);
            chk("rst_out_d", 64'(out_d), 64'd0);
            m_beats.delete();
            m_off  = 1'b0;
            m_word = '0;
        end else begin
            exp_in_a = in_v && (!m_off || out_a);
            chk("in_a", 64'(in_a), 64'(exp_in_a));
            chk("out_v", 64'(out_v), 64'(m_off));
            if (m_off) chk("out_d", 64'(out_d), 64'(m_word));
            if (out_v && out_a) got.push_back(out_d);
            was_off = m_off;
            if (m_off && out_a) m_off = 1'b0;
            if (in_v && exp_in_a) m_beats.push_back(in_d);
            if (m_beats.size() == K) begin
                m_word = pack_beats();
                m_off  = 1'b1;
                m_beats.delete();
            end
`ifdef CHANNEL_DESER_FLUSH_EN
            else if (flush && !was_off && (m_beats.size() > 0)) begin
                m_word = pack_beats();
                m_off  = 1'b1;
                m_beats.delete();
            end
`endif
        end
    end

    task automatic cyc(input logic v, input logic [NIN-1:0] d, input logic oa, input logic rs);
        @(negedge clk);
        reset = rs;
        in_v  = v;
        in_d  = d;
        out_a = oa;
        #3;
    endtask

`ifdef CHANNEL_DESER_FLUSH_EN
    task automatic cycf(input logic v, input logic [NIN-1:0] d, input logic oa, input logic fl);
        @(negedge clk);
        reset = 1'b1;
        flush = fl;
        in_v  = v;
        in_d  = d;
        out_a = oa;
        #3;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_off = 1'b0;
        m_word = '0;
        reset = 1'b0;
        in_v  = 1'b0;
        in_d  = '0;
        out_a = 1'b0;
`ifdef CHANNEL_DESER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);

        // Four beats make one word, offered exactly one cycle after the last beat.
        got.delete();
        cyc(1'b1, 8'h11, 1'b1, 1'b1);
        cyc(1'b1, 8'h22, 1'b1, 1'b1);
        cyc(1'b1, 8'h33, 1'b1, 1'b1);
        cyc(1'b1, 8'h44, 1'b1, 1'b1);
        chk("s1_not_early", 64'(out_v), 64'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("s1_out_v", 64'(out_v), 64'd1);
        chk("s1_out_d", 64'(out_d), 64'h44332211);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("s1_out_v_drop", 64'(out_v), 64'd0);
        chk("s1_count", 64'(got.size()), 64'd1);

        // Back-to-back beats with no bubbles.
        got.delete();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b1);
            chk("s2_in_a", 64'(in_a), 64'd1);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("s2_count", 64'(got.size()), 64'd2);
        chk("s2_word0", 64'(got[0]), 64'h04030201);
        chk("s2_word1", 64'(got[1]), 64'h08070605);

        // Stall on out: the word stays put and input is refused, then zero-bubble hand-off.
        got.delete();
        cyc(1'b1, 8'h11, 1'b0, 1'b1);
        cyc(1'b1, 8'h22, 1'b0, 1'b1);
        cyc(1'b1, 8'h33, 1'b0, 1'b1);
        cyc(1'b1, 8'h44, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h55, 1'b0, 1'b1);
            chk("s3_hold_in_a", 64'(in_a), 64'd0);
            chk("s3_hold_out_d", 64'(out_d), 64'h44332211);
        end
        cyc(1'b1, 8'h55, 1'b1, 1'b1);
        chk("s3_release_in_a", 64'(in_a), 64'd1);
        chk("s3_count", 64'(got.size()), 64'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);

        // Reset mid-word discards the partial word.
        got.delete();
        cyc(1'b1, 8'hAA, 1'b1, 1'b1);
        cyc(1'b1, 8'hBB, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("s4_count", 64'(got.size()), 64'd1);
        chk("s4_word", 64'(got[0]), 64'h04030201);

`ifdef CHANNEL_DESER_FLUSH_EN
        // Flush with a coinciding beat, then flush on an empty word.
        got.delete();
        cycf(1'b1, 8'hAA, 1'b1, 1'b0);
        cycf(1'b1, 8'hBB, 1'b1, 1'b1);
        cycf(1'b0, 8'h00, 1'b1, 1'b0);
        chk("s5_out_d", 64'(out_d), 64'h0000BBAA);
        for (int i = 0; i < 3; i++) cycf(1'b0, 8'h00, 1'b1, 1'b1);
        cycf(1'b0, 8'h00, 1'b1, 1'b0);
        chk("s5_empty_out_v", 64'(out_v), 64'd0);
        chk("s5_count", 64'(got.size()), 64'd1);
        chk("s5_word", 64'(got[0]), 64'h0000BBAA);
`endif

        // Random traffic with back-pressure and occasional resets.
        for (int i = 0; i < 2000; i++) begin
`ifdef CHANNEL_DESER_FLUSH_EN
            @(negedge clk);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 149) != 0);
            in_v  = ($urandom_range(0, 3) != 0);
            in_d  = 8'($urandom);
            out_a = ($urandom_range(0, 2) != 0);
            #3;
`else
            cyc(($urandom_range(0, 3) != 0), 8'($urandom),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 149) != 0));
`endif
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/channel_deserializer.md
CHANNEL_DESERIALIZER -- requirements
Module: channel_deserializer

Interface
REQ-001 The block SHALL have parameter NIN, default 8: width in bits of one input beat.
REQ-002 The block SHALL have parameter K, default 4, legal range 1..16: beats per output word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in, Channel (d/v in, a out), NIN bits: narrow input beats.
REQ-006 The block SHALL have port out, Channel (d/v out, a in), NIN*K bits: assembled wide words.
REQ-007 The block SHALL have port flush, input, 1 bit, present only when CHANNEL_DESER_FLUSH_EN is defined: request to emit a partial word.

Function
REQ-008 The block SHALL implement two states: FILL (collecting beats) and HOLD (word offered on out).
REQ-009 The block SHALL hold a beat counter cnt, width clog2(K) with a minimum of 1, counting 0..K-1 in FILL.
REQ-010 In FILL, in.a SHALL equal in.v, combinationally.
REQ-011 An accepted beat SHALL be written to out.d[cnt*NIN +: NIN], so the first beat lands in the LSBs.
REQ-012 A beat accepted in FILL with cnt==K-1 SHALL move the block to HOLD on the next edge, with out.v=1 from that cycle.
REQ-013 In HOLD, out.v SHALL be 1 and out.d SHALL be stable until out.a.
REQ-014 Handshake on out SHALL complete when out.v & out.a are both high in the same cycle; out.d SHALL not change while out.v=1 and out.a=0.
REQ-015 In HOLD, in.a SHALL equal in.v & out.a, allowing a zero-bubble hand-off.
REQ-016 On out.a with no input beat, the block SHALL go to FILL with cnt=0 and the word register cleared to 0.
REQ-017 On out.a with a simultaneous input beat and K>1, the block SHALL go to FILL with cnt=1, slot 0 holding the new beat and all other slots 0.
REQ-018 On out.a with a simultaneous input beat and K==1, the block SHALL stay in HOLD with the new beat as the word.
REQ-019 Sustained throughput SHALL be one input beat per cycle and one output word per K cycles, with no bubbles.
REQ-020 Latency SHALL be one cycle from acceptance of the last beat of a word to out.v=1.

Reset
REQ-021 While reset=0, the block SHALL hold state=FILL, cnt=0, word register=0, out.v=0 and in.a=0.
REQ-022 Asserting reset mid-word or in HOLD SHALL discard the partial or offered word with no output.
REQ-023 After reset release, the first accepted beat SHALL be treated as slot 0.

Configuration
REQ-024 With CHANNEL_DESER_FLUSH_EN defined: in FILL, flush=1 with cnt>0 SHALL move the block to HOLD next edge and emit the partial word with unfilled slots 0.
REQ-025 With CHANNEL_DESER_FLUSH_EN defined: if flush coincides with an accepted beat, the beat SHALL be included before the flush applies.
REQ-026 With CHANNEL_DESER_FLUSH_EN defined: flush with cnt==0 and no beat, or flush in HOLD, SHALL be ignored.
REQ-027 Without CHANNEL_DESER_FLUSH_EN: the flush port and its logic SHALL be absent, and a word SHALL be emitted only after K beats.

Structure
REQ-028 The state enum (FILL, HOLD) SHALL be defined in the shared package channel_util_pkg.
REQ-029 The block SHALL include Channel.svh for the Channel interface.
REQ-030 The block SHALL be a single module with no sub-module; a channel FIFO may be added downstream by the integrator.

Verification (NIN=8, K=4)
REQ-031 Beats 0x11,0x22,0x33,0x44 with out.a=1 SHALL produce one word 0x44332211, with out.v high exactly one cycle after the 0x44 beat is accepted.
REQ-032 Continuous in.v with out.a=1 over 8 beats 0x01..0x08 SHALL produce words 0x04030201 then 0x08070605, with in.a never low.
REQ-033 out.a held 0 for 5 cycles in HOLD SHALL keep out.d=0x44332211 stable and in.a=0 throughout; on release, the next beat 0x55 SHALL be accepted in the same cycle.
REQ-034 reset pulsed after beats 0xAA,0xBB, followed by beats 0x01..0x04, SHALL produce only the word 0x04030201.
REQ-035 With CHANNEL_DESER_FLUSH_EN, beats 0xAA,0xBB with flush asserted during the 0xBB cycle SHALL produce 0x0000BBAA; a subsequent flush with cnt==0 SHALL produce no word.
